// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register file and its bench.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

endpackage

// File: rtl/reg16_en.sv
// Single register with async active-high reset, synchronous clear and load.
// Clear wins over load so a sweep always zeroes its target.
module reg16_en
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_bank16.sv
// Sixteen-entry register file with single write port and a one-register-per-cycle
// bulk-clear sweep. Define REG_BANK_R0_ZERO_EN to hardwire r0 to zero.
module reg_bank16 #(
    parameter int WIDTH  = cpu_pkg::DATA_W,
    parameter int NREGS  = cpu_pkg::NREGS,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_drop,
    output logic [WIDTH-1:0]  r0,
    output logic [WIDTH-1:0]  r1,
    output logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  r3,
    output logic [WIDTH-1:0]  r4,
    output logic [WIDTH-1:0]  r5,
    output logic [WIDTH-1:0]  r6,
    output logic [WIDTH-1:0]  r7,
    output logic [WIDTH-1:0]  r8,
    output logic [WIDTH-1:0]  r9,
    output logic [WIDTH-1:0]  r10,
    output logic [WIDTH-1:0]  r11,
    output logic [WIDTH-1:0]  r12,
    output logic [WIDTH-1:0]  r13,
    output logic [WIDTH-1:0]  r14,
    output logic [WIDTH-1:0]  r15
);

    import cpu_pkg::*;

`ifdef REG_BANK_R0_ZERO_EN
    localparam bit R0Zero = 1'b1;
`else
    localparam bit R0Zero = 1'b0;
`endif

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              wrAccept;
    logic [WIDTH-1:0]  regVal [NREGS];

    // Writes are only honoured in IDLE; any write seen during the sweep is dropped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        wrAccept = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (R0Zero && (wr_addr == '0)) begin
                        drop_d = 1'b1;
                    end else begin
                        wrAccept = 1'b1;
                    end
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                drop_d = wr_en;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(NREGS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : gRegs
        if (R0Zero && (i == 0)) begin : gZero
            assign regVal[i] = '0;
        end else begin : gFlop
            logic loadEn;
            logic clrEn;
            assign loadEn = wrAccept && (wr_addr == ADDR_W'(i));
            assign clrEn  = (state_q == CLEAR) && (cnt_q == ADDR_W'(i));
            reg16_en #(.WIDTH(WIDTH)) uReg (
                .clk_i (clk),
                .rst_i (reset),
                .load_i(loadEn),
                .clr_i (clrEn),
                .d_i   (wr_data),
                .q_o   (regVal[i])
            );
        end
    end

    assign clr_busy = busy_q;
    assign clr_done = done_q;
    assign wr_drop  = drop_q;

    assign r0  = regVal[0];
    assign r1  = regVal[1];
    assign r2  = regVal[2];
    assign r3  = regVal[3];
    assign r4  = regVal[4];
    assign r5  = regVal[5];
    assign r6  = regVal[6];
    assign r7  = regVal[7];
    assign r8  = regVal[8];
    assign r9  = regVal[9];
    assign r10 = regVal[10];
    assign r11 = regVal[11];
    assign r12 = regVal[12];
    assign r13 = regVal[13];
    assign r14 = regVal[14];
    assign r15 = regVal[15];

endmodule
